// File: rtl/ahb_chk_pkg.sv
// ahb_chk_pkg: shared AHB-lite encodings, error-bit indices and burst length helper
// Contents: htrans_e, hburst_e, ERR_* bit positions into err_pulse/err_sticky,
//           NUM_ERR, burst_len() (beats per burst, 0 for unbounded INCR).
package ahb_chk_pkg;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'd0,
        TR_BUSY   = 2'd1,
        TR_NONSEQ = 2'd2,
        TR_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        BU_SINGLE = 3'd0,
        BU_INCR   = 3'd1,
        BU_WRAP4  = 3'd2,
        BU_INCR4  = 3'd3,
        BU_WRAP8  = 3'd4,
        BU_INCR8  = 3'd5,
        BU_WRAP16 = 3'd6,
        BU_INCR16 = 3'd7
    } hburst_e;

    localparam int ERR_SEQ_NO_BURST = 0;
    localparam int ERR_ADDR         = 1;
    localparam int ERR_CTRL         = 2;
    localparam int ERR_EARLY_END    = 3;
    localparam int ERR_OVERRUN      = 4;
    localparam int ERR_STALL_CHANGE = 5;
    localparam int ERR_WAIT_TIMEOUT = 6;
    localparam int ERR_KB_CROSS     = 7;
    localparam int ERR_HSIZE_WIDE   = 8;
    localparam int NUM_ERR          = 9;

    // HBURST[2:1] selects 4/8/16 beats for every fixed-length burst type.
    function automatic logic [4:0] burst_len(input hburst_e b);
        return b == BU_SINGLE ? 5'd1 : b == BU_INCR ? 5'd0 : 5'd2 << b[2:1];
    endfunction

endpackage

// File: rtl/ahb_next_addr.sv
// ahb_next_addr: combinational next-beat address and 1 KB boundary crossing
// Ports: addr      in  current beat address
//        size      in  HSIZE of the burst
//        burst     in  HBURST of the burst
//        next_addr out address the following beat must use
//        kb_cross  out next_addr of an incrementing burst lies in a different 1 KB page
module ahb_next_addr
    import ahb_chk_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [2:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  kb_cross
);

    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    logic                  wrap;

    assign inc  = addr + (ADDR_WIDTH'(1) << size);
    assign wrap = !burst[0] && burst != BU_SINGLE;
    // Wrap block is Len*2**size bytes; only the offset inside it advances.
    assign mask = (ADDR_WIDTH'(burst_len(hburst_e'(burst))) << size) - ADDR_WIDTH'(1);
    assign next_addr = wrap ? (addr & ~mask) | (inc & mask) : inc;
    assign kb_cross  = !wrap && inc[ADDR_WIDTH-1:10] != addr[ADDR_WIDTH-1:10];

endmodule

// File: rtl/ahb_lite_burst_checker.sv
// ahb_lite_burst_checker: passive AHB-lite burst/protocol checker with per-rule error reporting
// Ports: clk, HRESETn (async active-low), HTRANS, HBURST, HSIZE, HWRITE, HADDR,
//        HREADY, HRESP        monitored bus signals
//        err_clr              sync clear of err_sticky/err_count
//        err_pulse            one-cycle pulse per rule (ERR_* index)
//        err_sticky           accumulated err_pulse
//        err_count            saturating count of cycles with any error
//        beat_cnt             beats accepted in the open burst
//        burst_done           pulse on the last beat of a fixed-length burst
module ahb_lite_burst_checker
    import ahb_chk_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  HRESETn,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HBURST,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic                  err_clr,
    output logic [NUM_ERR-1:0]    err_pulse,
    output logic [NUM_ERR-1:0]    err_sticky,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [4:0]            beat_cnt,
    output logic                  burst_done
);

    localparam int WW       = $clog2(MAX_WAIT + 1);
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {S_IDLE, S_FIXED, S_UNDEF} state_e;

    state_e                st;
    logic [ADDR_WIDTH-1:0] exp_addr, prev_addr, next_addr;
    logic [2:0]            lat_burst, lat_size, prev_burst, prev_size;
    logic [1:0]            prev_trans;
    logic                  lat_write, prev_write, prev_pend, resp_seen, exp_cross, next_cross;
    logic [WW-1:0]         wait_cnt;
    logic [4:0]            len;
    logic                  nonseq_acc, seq_acc, in_burst;
    logic [NUM_ERR-1:0]    err;

    assign nonseq_acc = HREADY && HTRANS == TR_NONSEQ;
    assign seq_acc    = HREADY && HTRANS == TR_SEQ;
    assign in_burst   = st != S_IDLE;
    assign len        = burst_len(hburst_e'(lat_burst));

    // A NONSEQ starts from its own control; a SEQ continues with the latched control.
    ahb_next_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_next (
        .addr      (HADDR),
        .size      (nonseq_acc ? HSIZE : lat_size),
        .burst     (nonseq_acc ? HBURST : lat_burst),
        .next_addr (next_addr),
        .kb_cross  (next_cross)
    );

    always_comb begin
        err = '0;
        err[ERR_SEQ_NO_BURST] = !in_burst && HREADY && (HTRANS == TR_SEQ || HTRANS == TR_BUSY);
        err[ERR_ADDR]         = seq_acc && in_burst && HADDR != exp_addr;
        err[ERR_CTRL]         = seq_acc && in_burst && {HBURST, HSIZE, HWRITE} != {lat_burst, lat_size, lat_write};
        // An ERROR response (earlier in the burst or right now) makes an abort legal.
        err[ERR_EARLY_END]    = st == S_FIXED && HREADY && (HTRANS == TR_IDLE || HTRANS == TR_NONSEQ)
                                && !resp_seen && !HRESP;
        err[ERR_OVERRUN]      = seq_acc && !in_burst && burst_done;
        err[ERR_STALL_CHANGE] = prev_pend && {HTRANS, HADDR, HBURST, HSIZE, HWRITE}
                                != {prev_trans, prev_addr, prev_burst, prev_size, prev_write};
        err[ERR_WAIT_TIMEOUT] = !HREADY && wait_cnt == WW'(MAX_WAIT - 1);
        err[ERR_KB_CROSS]     = seq_acc && in_burst && exp_cross;
        err[ERR_HSIZE_WIDE]   = (nonseq_acc || seq_acc) && HSIZE > 3'(MAX_SIZE);
    end

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            st         <= S_IDLE;
            err_pulse  <= '0;
            err_sticky <= '0;
            err_count  <= '0;
            beat_cnt   <= '0;
            burst_done <= 1'b0;
            exp_addr   <= '0;
            exp_cross  <= 1'b0;
            lat_burst  <= '0;
            lat_size   <= '0;
            lat_write  <= 1'b0;
            resp_seen  <= 1'b0;
            prev_pend  <= 1'b0;
            prev_trans <= '0;
            prev_addr  <= '0;
            prev_burst <= '0;
            prev_size  <= '0;
            prev_write <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            err_pulse  <= err;
            err_sticky <= err_clr ? '0 : err_sticky | err;
            err_count  <= err_clr ? '0 : (|err && !(&err_count)) ? err_count + CNT_WIDTH'(1) : err_count;
            burst_done <= 1'b0;
            prev_pend  <= !HREADY && HTRANS[1];
            {prev_trans, prev_addr, prev_burst, prev_size, prev_write} <= {HTRANS, HADDR, HBURST, HSIZE, HWRITE};
            // Saturating at MAX_WAIT keeps the timeout to a single pulse per stall.
            wait_cnt   <= HREADY ? '0 : wait_cnt == WW'(MAX_WAIT) ? wait_cnt : wait_cnt + WW'(1);
            if (nonseq_acc || (seq_acc && in_burst)) begin
                exp_addr  <= next_addr;
                exp_cross <= next_cross;
            end
            if (nonseq_acc) begin
                {lat_burst, lat_size, lat_write} <= {HBURST, HSIZE, HWRITE};
                resp_seen <= 1'b0;
                beat_cnt  <= 5'd1;
                st        <= HBURST == BU_SINGLE ? S_IDLE : HBURST == BU_INCR ? S_UNDEF : S_FIXED;
            end else begin
                resp_seen <= resp_seen | HRESP;
                if (seq_acc && in_burst) begin
                    beat_cnt <= beat_cnt + 5'(!(&beat_cnt));
                    if (st == S_FIXED && beat_cnt + 5'd1 == len) begin
                        st         <= S_IDLE;
                        burst_done <= 1'b1;
                    end
                end else if (!in_burst || (HREADY && HTRANS == TR_IDLE)) begin
                    st       <= S_IDLE;
                    beat_cnt <= '0;
                end
            end
        end
    end

endmodule
